// File: rtl/mem_bank_param.sv
// Parametrised single-port RAM with per-byte write enables and a registered read port.
// A clear engine sweeps CLR_VALUE into every word after reset or on a clr pulse.
module mem_bank_param #(
   parameter int                DATA_W    = 16,
   parameter int                BYTE_W    = 8,
   parameter int                ADDR_W    = 8,
   parameter int                DEPTH     = 256,
   parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ADDR_W-1:0]          addr,
   input  logic [DATA_W-1:0]          din,
   input  logic [DATA_W/BYTE_W-1:0]   be,
   input  logic                       en,
   input  logic                       rd_en,
   input  logic                       clr,
   output logic [DATA_W-1:0]          dout,
   output logic                       dout_vld,
   output logic                       busy
);

   localparam int NB = DATA_W / BYTE_W;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   cnt;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                in_range;
   logic                user_wr;
   logic                user_rd;
   logic [DATA_W-1:0]   rd_word;
   logic [DATA_W-1:0]   merged;
   logic                wr_any;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic [NB-1:0]       wr_lanes;

   assign in_range = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
   assign user_wr  = (state == IDLE) && en && in_range;
   assign user_rd  = (state == IDLE) && rd_en;
   assign busy     = (state == CLEAR);

   // Write-first read data: enabled lanes come from din, the rest from the array.
   always_comb begin
      rd_word = '0;
      if (in_range) rd_word = mem[addr];
      merged = rd_word;
      for (int k = 0; k < NB; k++) begin
         if (user_wr && be[k]) merged[k*BYTE_W +: BYTE_W] = din[k*BYTE_W +: BYTE_W];
      end
   end

   // The sweep and user writes never overlap, so they share one write port.
   always_comb begin
      if (state == CLEAR) begin
         wr_any   = 1'b1;
         wr_addr  = cnt;
         wr_data  = CLR_VALUE;
         wr_lanes = '1;
      end else begin
         wr_any   = user_wr;
         wr_addr  = addr;
         wr_data  = din;
         wr_lanes = be;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_any) begin
         for (int k = 0; k < NB; k++) begin
            if (wr_lanes[k]) mem[wr_addr][k*BYTE_W +: BYTE_W] <= wr_data[k*BYTE_W +: BYTE_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= CLEAR;
         cnt      <= '0;
         dout     <= '0;
         dout_vld <= 1'b0;
      end else begin
         dout_vld <= 1'b0;
         case (state)
            CLEAR: begin
               if (cnt == ADDR_W'(DEPTH-1)) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + ADDR_W'(1);
               end
            end
            IDLE: begin
               if (user_rd) begin
                  dout     <= merged;
                  dout_vld <= 1'b1;
               end
               if (clr) begin
                  state <= CLEAR;
                  cnt   <= '0;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bank_param.sv
// Scoreboard bench for mem_bank_param: reads push expected words, a monitor pops on dout_vld.
// A second instance with DEPTH=200 covers out-of-range addressing.
module tb_mem_bank_param;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  addr;
   logic [15:0] din;
   logic [1:0]  be;
   logic        en, rd_en, clr;
   logic [15:0] dout;
   logic        dout_vld, busy;

   logic [7:0]  addr2;
   logic [15:0] din2;
   logic [1:0]  be2;
   logic        en2, rd_en2, clr2;
   logic [15:0] dout2;
   logic        dout_vld2, busy2;

   logic [15:0] exp_q[$];
   int          n_total = 0;
   int          n_pass  = 0;

   always #5 clk = ~clk;

   mem_bank_param dut (
      .clk(clk), .rst(rst), .addr(addr), .din(din), .be(be), .en(en),
      .rd_en(rd_en), .clr(clr), .dout(dout), .dout_vld(dout_vld), .busy(busy)
   );

   mem_bank_param #(.DEPTH(200)) dut2 (
      .clk(clk), .rst(rst), .addr(addr2), .din(din2), .be(be2), .en(en2),
      .rd_en(rd_en2), .clr(clr2), .dout(dout2), .dout_vld(dout_vld2), .busy(busy2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // Monitor: every dout_vld pulse must match the oldest outstanding read.
   always @(negedge clk) begin
      if (dout_vld === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_vld: dout=0x%0h with no read outstanding at %0t", dout, $time);
         end else begin
            chk("rd_data", {16'h0, dout}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic idle_inputs();
      en = 1'b0; rd_en = 1'b0; clr = 1'b0; be = 2'b00; din = '0; addr = '0;
   endtask

   // All drive tasks start and end on a falling edge.
   task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
      addr = a; din = d; be = b; en = 1'b1;
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic rd(input logic [7:0] a, input logic [15:0] e);
      addr = a; rd_en = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic wr_rd(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b,
                        input logic [15:0] e);
      addr = a; din = d; be = b; en = 1'b1; rd_en = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      idle_inputs();
   endtask

   // Counts rising edges seen with busy high; inputs set before the call last one edge.
   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 2000) begin
         n++;
         @(negedge clk);
         idle_inputs();
      end
   endtask

   task automatic count_busy2(output int n);
      n = 0;
      while (busy2 && n < 2000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic rd2(input logic [7:0] a, input logic [15:0] e, input string name);
      addr2 = a; rd_en2 = 1'b1;
      @(negedge clk);
      rd_en2 = 1'b0;
      chk({name, "_vld"}, {31'h0, dout_vld2}, 32'h1);
      chk(name, {16'h0, dout2}, {16'h0, e});
   endtask

   initial begin
      int n, n2;
      rst = 1'b1;
      idle_inputs();
      addr2 = '0; din2 = '0; be2 = '0; en2 = 1'b0; rd_en2 = 1'b0; clr2 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'h1);
      chk("rst_dout", {16'h0, dout}, 32'h0);
      chk("rst_vld", {31'h0, dout_vld}, 32'h0);

      // 1. initial sweep length, then a cleared word
      rst = 1'b0;
      count_busy(n);
      chk("sweep_after_rst", n, 256);
      rd(8'd5, 16'h0000);

      // 2. full-width write of every address, then read back
      for (int i = 0; i < 256; i++) wr(8'(i), 16'(i), 2'b11);
      for (int i = 0; i < 256; i++) rd(8'(i), 16'(i));

      // 3. byte lanes
      wr(8'd3, 16'h1234, 2'b11);
      wr(8'd3, 16'hABCD, 2'b01);
      rd(8'd3, 16'h12CD);
      wr(8'd3, 16'hEF00, 2'b10);
      rd(8'd3, 16'hEFCD);
      wr(8'd3, 16'hFFFF, 2'b00);
      rd(8'd3, 16'hEFCD);

      // 4. same-cycle read and write are write-first, merged per lane
      wr_rd(8'd7, 16'h5A5A, 2'b11, 16'h5A5A);
      wr_rd(8'd8, 16'h7700, 2'b10, 16'h7708);
      rd(8'd8, 16'h7708);

      // 5. clr with write and read in the same cycle, then accesses while busy are ignored
      addr = 8'd7; din = 16'h1111; be = 2'b11; en = 1'b1; rd_en = 1'b1; clr = 1'b1;
      exp_q.push_back(16'h1111);
      @(negedge clk);
      idle_inputs();
      chk("busy_after_clr", {31'h0, busy}, 32'h1);
      addr = 8'd9; din = 16'hFFFF; be = 2'b11; en = 1'b1; rd_en = 1'b1;
      count_busy(n);
      chk("sweep_after_clr", n, 256);
      rd(8'd9, 16'h0000);
      rd(8'd7, 16'h0000);
      rd(8'd255, 16'h0000);

      // 6. reset in the middle of a sweep
      wr(8'd1, 16'h4321, 2'b11);
      rd(8'd1, 16'h4321);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (100) @(negedge clk);
      chk("busy_mid_sweep", {31'h0, busy}, 32'h1);
      chk("dout_hold_before_rst", {16'h0, dout}, 32'h4321);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_busy", {31'h0, busy}, 32'h1);
      chk("rst_async_dout", {16'h0, dout}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      fork
         count_busy(n);
         count_busy2(n2);
      join
      chk("sweep_after_mid_rst", n, 256);
      chk("sweep_depth200", n2, 200 - 256 + 256);
      rd(8'd1, 16'h0000);

      // DEPTH=200: out-of-range write dropped, read returns zero with a valid pulse
      addr2 = 8'd199; din2 = 16'hC0DE; be2 = 2'b11; en2 = 1'b1;
      @(negedge clk);
      en2 = 1'b0;
      rd2(8'd199, 16'hC0DE, "d200_last");
      addr2 = 8'd250; din2 = 16'hFFFF; be2 = 2'b11; en2 = 1'b1;
      @(negedge clk);
      en2 = 1'b0;
      rd2(8'd250, 16'h0000, "d200_oob");
      rd2(8'd199, 16'hC0DE, "d200_last_again");

      repeat (3) @(negedge clk);
      chk("reads_outstanding", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
